led_pattern_gen: RTL and testbench

Parametrised LED pattern generator that supersedes the single-mode LED rotator on the board LED bank. It holds one NB_LEDS-wide pattern register. It advances the pattern on prescaled step ticks. Four run-time modes are supported: rotate left, rotate right, ping-pong bounce and alternating flash. It sits between the board switch/button synchronisers and the LED pins.

---
 rtl/led_pattern_gen.sv | 96 +++++++++
 tb/tb_led_pattern_gen.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
// LED pattern generator: rotate left/right, ping-pong bounce and alternating flash,
// advanced on prescaled step ticks while i_valid is high.
module led_pattern_gen #(
  parameter int unsigned NB_LEDS     = 4,
  parameter int unsigned NB_PRESCALE = 8
) (
  input  logic                   clock,
  input  logic                   i_reset,
  input  logic                   i_valid,
  input  logic [1:0]             i_mode,
  input  logic [NB_PRESCALE-1:0] i_prescale,
  output logic [NB_LEDS-1:0]     o_led,
  output logic                   o_step,
  output logic                   o_dir
);

  localparam logic [NB_LEDS-1:0]   LedSeed   = NB_LEDS'(1);
  localparam logic [2*NB_LEDS-1:0] FlashRep  = {NB_LEDS{2'b01}};
  localparam logic [NB_LEDS-1:0]   FlashSeed = FlashRep[NB_LEDS-1:0];

  localparam logic [1:0] ModeRotL  = 2'b00;
  localparam logic [1:0] ModeRotR  = 2'b01;
  localparam logic [1:0] ModePing  = 2'b10;
  localparam logic [1:0] ModeFlash = 2'b11;

  logic [NB_LEDS-1:0]     led_q, led_d;
  logic [NB_PRESCALE-1:0] cnt_q, cnt_d;
  logic                   dir_q, dir_d;
  logic                   step_q, step_d;
  logic [1:0]             mode_q, mode_d;

  always_comb begin
    led_d  = led_q;
    cnt_d  = cnt_q;
    dir_d  = dir_q;
    step_d = 1'b0;
    mode_d = mode_q;
    if (i_reset) begin
      led_d  = LedSeed;
      cnt_d  = '0;
      dir_d  = 1'b0;
      mode_d = ModeRotL;
    end else if (i_mode != mode_q) begin
      // A mode change discards any step due in the same cycle.
      mode_d = i_mode;
      cnt_d  = '0;
      dir_d  = 1'b0;
      led_d  = (i_mode == ModeFlash) ? FlashSeed : LedSeed;
    end else if (i_valid) begin
      if (cnt_q == i_prescale) begin
        cnt_d  = '0;
        step_d = 1'b1;
        unique case (mode_q)
          ModeRotL: led_d = {led_q[NB_LEDS-2:0], led_q[NB_LEDS-1]};
          ModeRotR: led_d = {led_q[0], led_q[NB_LEDS-1:1]};
          ModePing: begin
            // Reverse at the ends and move in the same step, so end LEDs do not dwell.
            if (!dir_q) begin
              if (led_q[NB_LEDS-1]) begin
                dir_d = 1'b1;
                led_d = led_q >> 1;
              end else begin
                led_d = led_q << 1;
              end
            end else begin
              if (led_q[0]) begin
                dir_d = 1'b0;
                led_d = led_q << 1;
              end else begin
                led_d = led_q >> 1;
              end
            end
          end
          ModeFlash: led_d = ~led_q;
          default:   led_d = led_q;
        endcase
      end else begin
        // Equality-only compare: a lowered terminal count is reached after wrap-around.
        cnt_d = cnt_q + NB_PRESCALE'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    led_q  <= led_d;
    cnt_q  <= cnt_d;
    dir_q  <= dir_d;
    step_q <= step_d;
    mode_q <= mode_d;
  end

  assign o_led  = led_q;
  assign o_step = step_q;
  assign o_dir  = dir_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen with NB_LEDS=4, NB_PRESCALE=8.
module tb_led_pattern_gen;

  logic       clock;
  logic       i_reset;
  logic       i_valid;
  logic [1:0] i_mode;
  logic [7:0] i_prescale;
  logic [3:0] o_led;
  logic       o_step;
  logic       o_dir;

  int n_checks;
  int n_errors;

  led_pattern_gen #(
    .NB_LEDS    (4),
    .NB_PRESCALE(8)
  ) dut (
    .clock     (clock),
    .i_reset   (i_reset),
    .i_valid   (i_valid),
    .i_mode    (i_mode),
    .i_prescale(i_prescale),
    .o_led     (o_led),
    .o_step    (o_step),
    .o_dir     (o_dir)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; outputs are then sampled 1 time unit later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] led, input logic step,
                            input logic dir);
    check({tag, ".led"}, {28'd0, o_led}, {28'd0, led});
    check({tag, ".step"}, {31'd0, o_step}, {31'd0, step});
    check({tag, ".dir"}, {31'd0, o_dir}, {31'd0, dir});
  endtask

  logic [3:0] rl_led [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] pp_led [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
  logic       pp_dir [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic       v_pat  [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    int steps_seen;
    n_checks   = 0;
    n_errors   = 0;
    i_reset    = 1'b1;
    i_valid    = 1'b0;
    i_mode     = 2'b00;
    i_prescale = 8'd0;
    #1;
    tick();
    tick();
    expect_out("reset", 4'b0001, 1'b0, 1'b0);

    // Rotate left, step every valid cycle.
    i_reset = 1'b0;
    i_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_out($sformatf("rotl%0d", i), rl_led[i], 1'b1, 1'b0);
    end

    // Ping-pong: mode-change cycle loads the seed, then bounce.
    i_mode = 2'b10;
    tick();
    expect_out("pp_seed", 4'b0001, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      tick();
      expect_out($sformatf("pp%0d", i), pp_led[i], 1'b1, pp_dir[i]);
    end

    // Rotate left with prescale 3 and a gap in i_valid: one step on the 4th valid edge.
    i_mode     = 2'b00;
    i_prescale = 8'd3;
    i_valid    = 1'b0;
    tick();
    expect_out("gap_seed", 4'b0001, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      i_valid = v_pat[i];
      tick();
      if (i < 5) expect_out($sformatf("gap%0d", i), 4'b0001, 1'b0, 1'b0);
      else       expect_out("gap_step", 4'b0010, 1'b1, 1'b0);
    end
    i_valid = 1'b0;
    tick();
    expect_out("gap_after", 4'b0010, 1'b0, 1'b0);

    // Reach 0100, then switch to flash while a step is also due: mode change wins.
    i_prescale = 8'd0;
    i_valid    = 1'b1;
    tick();
    expect_out("pre_flash", 4'b0100, 1'b1, 1'b0);
    i_mode     = 2'b11;
    i_prescale = 8'd1;
    tick();
    expect_out("flash_seed", 4'b0101, 1'b0, 1'b0);
    tick();
    expect_out("flash_wait0", 4'b0101, 1'b0, 1'b0);
    tick();
    expect_out("flash_step0", 4'b1010, 1'b1, 1'b0);
    tick();
    expect_out("flash_wait1", 4'b1010, 1'b0, 1'b0);
    tick();
    expect_out("flash_step1", 4'b0101, 1'b1, 1'b0);

    // Rotate right, prescale 2; reset lands where cnt==2 and suppresses the step.
    i_mode     = 2'b01;
    i_prescale = 8'd2;
    tick();
    expect_out("rotr_seed", 4'b0001, 1'b0, 1'b0);
    tick();
    tick();
    expect_out("rotr_cnt2", 4'b0001, 1'b0, 1'b0);
    i_reset = 1'b1;
    tick();
    expect_out("rotr_reset", 4'b0001, 1'b0, 1'b0);
    i_reset = 1'b0;
    // Reset returned the mode register to 00, so the first edge reloads mode 01 (cnt=0);
    // three further valid edges then produce the rotate-right step.
    tick();
    expect_out("rotr_reload", 4'b0001, 1'b0, 1'b0);
    tick();
    tick();
    expect_out("rotr_wait", 4'b0001, 1'b0, 1'b0);
    tick();
    expect_out("rotr_step", 4'b1000, 1'b1, 1'b0);

    // Lower the terminal count below cnt: count wraps through 255 before stepping.
    i_mode     = 2'b00;
    i_prescale = 8'd5;
    tick();
    expect_out("wrap_seed", 4'b0001, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    i_prescale = 8'd1;
    steps_seen = 0;
    // cnt 3 -> 4..255 -> 0 -> 1 takes 254 edges; the 255th edge steps.
    for (int i = 0; i < 254; i++) begin
      tick();
      if (o_step) steps_seen++;
    end
    check("wrap_no_early_step", steps_seen, 0);
    check("wrap_led_hold", {28'd0, o_led}, 32'h1);
    tick();
    expect_out("wrap_step", 4'b0010, 1'b1, 1'b0);
    tick();
    expect_out("wrap_after", 4'b0010, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
